// File: rtl/program_loader.sv
// program_loader: receives a byte-serial boot image, writes its words into core0 RAM,
// and holds core0 in reset until the image checksum verifies.
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    output logic        load,
    output logic [31:0] loadAddress,
    output logic [31:0] loadInstruction,
    output logic        core_reset,
    output logic        done,
    output logic [1:0]  error
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_HI = 3'd1;
    localparam logic [2:0] LEN_LO = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] CSUM   = 3'd5;
    localparam logic [2:0] RUN    = 3'd6;
    localparam logic [2:0] ERR    = 3'd7;

    logic [2:0]  state, nstate;
    logic [7:0]  len_hi, csum;
    logic [15:0] len, widx;
    logic [1:0]  bidx;
    logic [23:0] word;
    logic        accept, len_bad, last_word;
    logic [15:0] len_in;
    logic [31:0] word_in;

    assign accept    = rx_valid && rx_ready;
    assign len_in    = {len_hi, rx_byte};
    assign len_bad   = 32'(len_in) > MAX_WORDS;
    assign word_in   = {word, rx_byte};
    assign last_word = 16'(widx + 16'd1) == len;

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = (accept && rx_byte == 8'hA5) ? LEN_HI : IDLE;
            LEN_HI:  nstate = accept ? LEN_LO : LEN_HI;
            LEN_LO:  nstate = !accept ? LEN_LO : len_bad ? ERR : (len_in == 16'd0) ? CSUM : DATA;
            DATA:    nstate = (accept && bidx == 2'd3) ? WRITE : DATA;
            WRITE:   nstate = last_word ? CSUM : DATA;
            CSUM:    nstate = !accept ? CSUM : (rx_byte == csum) ? RUN : ERR;
            default: nstate = state;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge sclk) begin
        if (reset) begin
            state           <= IDLE;
            rx_ready        <= 1'b0;
            load            <= 1'b0;
            loadAddress     <= 32'h0;
            loadInstruction <= 32'h0;
            core_reset      <= 1'b1;
            done            <= 1'b0;
            error           <= 2'b00;
            len_hi          <= 8'h0;
            len             <= 16'h0;
            widx            <= 16'h0;
            bidx            <= 2'd0;
            word            <= 24'h0;
            csum            <= 8'h0;
        end else begin
            state      <= nstate;
            rx_ready   <= nstate inside {IDLE, LEN_HI, LEN_LO, DATA, CSUM};
            load       <= nstate == WRITE;
            done       <= nstate == RUN;
            core_reset <= nstate != RUN;
            if (state == DATA && nstate == WRITE) begin
                loadAddress     <= BASE_ADDR + {14'b0, widx, 2'b00};
                loadInstruction <= word_in;
            end
            if (accept)
                csum <= (state == IDLE) ? 8'h0 : csum ^ rx_byte;
            if (accept && state == LEN_HI)
                len_hi <= rx_byte;
            if (accept && state == LEN_LO) begin
                len  <= len_in;
                widx <= 16'h0;
                bidx <= 2'd0;
                if (len_bad)
                    error <= 2'b01;
            end
            if (accept && state == DATA) begin
                word <= word_in[23:0];
                bidx <= bidx + 2'd1;
            end
            if (state == WRITE)
                widx <= widx + 16'd1;
            if (accept && state == CSUM && rx_byte != csum)
                error <= 2'b10;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed byte streams against hand-computed writes, checksum and status.
module tb_program_loader;
    logic        sclk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h0;
    logic        rx_ready, load, core_reset, done;
    logic [31:0] loadAddress, loadInstruction;
    logic [1:0]  error;

    int          checks = 0;
    int          errors = 0;
    int          nw;
    logic [31:0] waddr [8];
    logic [31:0] wdata [8];
    logic [7:0]  img [12] = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56,
                              8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h28};

    program_loader dut (
        .sclk(sclk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .rx_ready(rx_ready), .load(load), .loadAddress(loadAddress),
        .loadInstruction(loadInstruction), .core_reset(core_reset),
        .done(done), .error(error)
    );

    always #5 sclk = ~sclk;

    // Capture every write strobe mid-cycle; the log clears while reset is held.
    always @(negedge sclk) begin
        if (reset) nw = 0;
        else if (load) begin
            if (nw < 8) begin
                waddr[nw] = loadAddress;
                wdata[nw] = loadInstruction;
            end
            nw++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge sclk);
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_byte = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge sclk);
            n++;
        end
        if (n >= 50) check("rdy_timeout", rx_ready, 1);
        @(negedge sclk);
        rx_valid = 1'b0;
    endtask

    task automatic send_img(input logic [7:0] last, input bit jitter);
        for (int i = 0; i < 11; i++) begin
            if (jitter) repeat ($urandom_range(0, 3)) @(negedge sclk);
            send(img[i]);
        end
        send(last);
    endtask

    initial begin
        @(negedge sclk);
        // reset state
        do_reset();
        check("rst_load", load, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_rx_ready", rx_ready, 0);
        @(negedge sclk);
        check("rdy_after_rst", rx_ready, 1);

        // two-word image, strobe timing and final status
        for (int i = 0; i < 7; i++) send(img[i]);
        check("load_latency", load, 1);
        check("w0_addr_live", loadAddress, 32'h0);
        check("w0_data_live", loadInstruction, 32'h12345678);
        check("rdy_in_write", rx_ready, 0);
        for (int i = 7; i < 12; i++) send(img[i]);
        check("t2_done", done, 1);
        check("t2_core_reset", core_reset, 0);
        check("t2_error", error, 0);
        check("t2_nw", nw, 2);
        check("t2_a0", waddr[0], 32'h0);
        check("t2_d0", wdata[0], 32'h12345678);
        check("t2_a1", waddr[1], 32'h4);
        check("t2_d1", wdata[1], 32'hDEADBEEF);
        repeat (3) @(negedge sclk);
        check("t2_done_sticky", done, 1);
        check("t2_addr_hold", loadAddress, 32'h4);
        check("t2_rdy_run", rx_ready, 0);

        // bad checksum
        do_reset();
        send_img(8'h29, 0);
        check("t3_error", error, 2);
        check("t3_done", done, 0);
        check("t3_core_reset", core_reset, 1);
        check("t3_nw", nw, 2);
        repeat (3) @(negedge sclk);
        check("t3_error_sticky", error, 2);
        check("t3_rdy_err", rx_ready, 0);

        // length 1025 rejected
        do_reset();
        send(8'hA5); send(8'h04); send(8'h01);
        check("t4_error", error, 1);
        check("t4_core_reset", core_reset, 1);
        repeat (6) @(negedge sclk);
        check("t4_nw", nw, 0);

        // length 1024 is accepted and enters data
        do_reset();
        send(8'hA5); send(8'h04); send(8'h00);
        check("max_error", error, 0);
        check("max_rdy", rx_ready, 1);

        // leading garbage, empty image
        do_reset();
        send(8'h00); send(8'hFF);
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        check("t5_done", done, 1);
        check("t5_core_reset", core_reset, 0);
        check("t5_nw", nw, 0);

        // reset mid-word, then a clean image
        do_reset();
        for (int i = 0; i < 5; i++) send(img[i]);
        do_reset();
        send_img(8'h28, 0);
        check("t6_nw", nw, 2);
        check("t6_d0", wdata[0], 32'h12345678);
        check("t6_d1", wdata[1], 32'hDEADBEEF);
        check("t6_done", done, 1);

        // rx_valid gaps do not change the outcome
        do_reset();
        send_img(8'h28, 1);
        check("j_nw", nw, 2);
        check("j_a1", waddr[1], 32'h4);
        check("j_d0", wdata[0], 32'h12345678);
        check("j_d1", wdata[1], 32'hDEADBEEF);
        check("j_done", done, 1);
        check("j_error", error, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
